// File: rtl/cpu_pkg.sv
// rtl/cpu_pkg.sv - shared opcode, instruction, state and write-select types for the control unit
package cpu_pkg;

  typedef enum logic [4:0] {
    OP_RSV0  = 5'd0,
    OP_ADD   = 5'd1,
    OP_ADDS  = 5'd2,
    OP_SUB   = 5'd3,
    OP_SUBS  = 5'd4,
    OP_AND   = 5'd5,
    OP_OR    = 5'd6,
    OP_XOR   = 5'd7,
    OP_NOT   = 5'd8,
    OP_SHL   = 5'd9,
    OP_SHR   = 5'd10,
    OP_ASR   = 5'd11,
    OP_ROL   = 5'd12,
    OP_ROR   = 5'd13,
    OP_MUL   = 5'd14,
    OP_INC   = 5'd15,
    OP_DEC   = 5'd16,
    OP_NEG   = 5'd17,
    OP_CMP   = 5'd18,
    OP_NOP   = 5'd19,
    OP_LOADI = 5'd20,
    OP_STORE = 5'd21,
    OP_MOV   = 5'd22,
    OP_J     = 5'd23,
    OP_BEQ   = 5'd24,
    OP_HLT   = 5'd25
  } opcode_e;

  typedef struct packed {
    logic [4:0] opcode;
    logic [8:0] dest;
    logic [8:0] src1;
    logic [8:0] src2;
  } instr_t;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MEM,
    S_WB,
    S_HALT
  } state_e;

  typedef enum logic [1:0] {
    WSEL_ALU  = 2'd0,
    WSEL_DMEM = 2'd1,
    WSEL_RF   = 2'd2
  } wsel_e;

  // Opcode 0 and everything above HLT is unassigned.
  function automatic logic is_reserved(input logic [4:0] op);
    return (op == OP_RSV0) || (op > OP_HLT);
  endfunction

endpackage

// File: rtl/cpu_decode.sv
// rtl/cpu_decode.sv - combinational opcode classifier
module cpu_decode (
  input  logic [4:0] opcode,
  output logic       is_alu,
  output logic       is_mem,
  output logic       is_jump,
  output logic       writes_rf,
  output logic       is_illegal
);
  import cpu_pkg::*;

  // Classify the opcode into the execution class the sequencer dispatches on.
  always_comb begin
    is_alu     = 1'b0;
    is_mem     = 1'b0;
    is_jump    = 1'b0;
    writes_rf  = 1'b0;
    is_illegal = is_reserved(opcode);
    if (opcode >= OP_ADD && opcode <= OP_CMP) begin
      is_alu    = 1'b1;
      writes_rf = (opcode != OP_CMP);
    end
    if (opcode == OP_LOADI || opcode == OP_STORE) begin
      is_mem = 1'b1;
    end
    if (opcode == OP_LOADI || opcode == OP_MOV) begin
      writes_rf = 1'b1;
    end
    if (opcode == OP_J || opcode == OP_BEQ) begin
      is_jump = 1'b1;
    end
  end

endmodule

// File: rtl/cpu_control_unit.sv
// rtl/cpu_control_unit.sv - multi-cycle fetch/decode/execute sequencer driving ALU, register file and data RAM
module cpu_control_unit #(
  parameter int              PC_W     = 9,
  parameter int              DATA_W   = 32,
  parameter int              ALU_LAT  = 1,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              run,
  output logic              imem_req,
  output logic [PC_W-1:0]   imem_addr,
  input  logic              imem_ack,
  input  logic [31:0]       imem_rdata,
  output logic [8:0]        rf_raddr1,
  output logic [8:0]        rf_raddr2,
  input  logic [DATA_W-1:0] rf_rdata1,
  input  logic [DATA_W-1:0] rf_rdata2,
  output logic              alu_en,
  output logic [4:0]        alu_op,
  input  logic [3:0]        alu_flags,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [8:0]        dmem_addr,
  input  logic              dmem_ack,
  output logic              rf_we,
  output logic [8:0]        rf_waddr,
  output logic [1:0]        rf_wsel,
  output logic [3:0]        flags,
  output logic [PC_W-1:0]   pc,
  output logic              halted,
  output logic              illegal
);
  import cpu_pkg::*;

  localparam int CNT_W = $clog2(ALU_LAT + 1);

  state_e             state;
  instr_t             ir;
  wsel_e              wsel_q;
  logic [CNT_W-1:0]   alu_cnt;
  logic [PC_W-1:0]    pc_inc;
  logic [PC_W-1:0]    target;
  logic               is_alu;
  logic               is_mem;
  logic               is_jump;
  logic               writes_rf;
  logic               is_illegal;

  cpu_decode u_decode (
    .opcode     (ir.opcode),
    .is_alu     (is_alu),
    .is_mem     (is_mem),
    .is_jump    (is_jump),
    .writes_rf  (writes_rf),
    .is_illegal (is_illegal)
  );

  // Operand addresses and opcode come straight from the held instruction.
  assign imem_addr = pc;
  assign rf_raddr1 = ir.src1;
  assign rf_raddr2 = ir.src2;
  assign alu_op    = ir.opcode;
  assign rf_waddr  = ir.dest;
  assign dmem_we   = (ir.opcode == OP_STORE);
  assign dmem_addr = dmem_we ? ir.dest : ir.src2;
  assign rf_wsel   = wsel_q;
  assign pc_inc    = pc + PC_W'(1);
  assign target    = ir.dest[PC_W-1:0];

  // Sequencer: state, PC, IR, ALU wait counter and all registered strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_FETCH;
      pc       <= RESET_PC;
      ir       <= '0;
      wsel_q   <= WSEL_ALU;
      alu_cnt  <= '0;
      imem_req <= 1'b0;
      dmem_req <= 1'b0;
      alu_en   <= 1'b0;
      rf_we    <= 1'b0;
      flags    <= 4'd0;
      halted   <= 1'b0;
      illegal  <= 1'b0;
    end else begin
      alu_en <= 1'b0;
      rf_we  <= 1'b0;
      case (state)
        S_FETCH: begin
          // run only gates the start of a fetch; a raised request waits for its ack.
          if (!imem_req) begin
            if (run) imem_req <= 1'b1;
          end else if (imem_ack) begin
            imem_req <= 1'b0;
            ir       <= imem_rdata;
            state    <= S_DECODE;
          end
        end
        S_DECODE: begin
          if (is_illegal) begin
            illegal <= 1'b1;
            pc      <= pc_inc;
            state   <= S_FETCH;
          end else if (is_alu) begin
            alu_en  <= 1'b1;
            alu_cnt <= '0;
            state   <= S_EXEC;
          end else if (is_mem) begin
            dmem_req <= 1'b1;
            state    <= S_MEM;
          end else if (is_jump) begin
            if (ir.opcode == OP_J || rf_rdata1 == rf_rdata2) pc <= target;
            else pc <= pc_inc;
            state <= S_FETCH;
          end else if (writes_rf) begin
            rf_we  <= 1'b1;
            wsel_q <= WSEL_RF;
            state  <= S_WB;
          end else if (ir.opcode == OP_HLT) begin
            halted <= 1'b1;
            state  <= S_HALT;
          end else begin
            pc    <= pc_inc;
            state <= S_FETCH;
          end
        end
        S_EXEC: begin
          // Flags are sampled exactly ALU_LAT cycles after the alu_en pulse.
          if (alu_cnt == CNT_W'(ALU_LAT)) begin
            flags <= alu_flags;
            if (writes_rf) begin
              rf_we  <= 1'b1;
              wsel_q <= WSEL_ALU;
              state  <= S_WB;
            end else begin
              pc    <= pc_inc;
              state <= S_FETCH;
            end
          end else begin
            alu_cnt <= alu_cnt + CNT_W'(1);
          end
        end
        S_MEM: begin
          if (dmem_ack) begin
            dmem_req <= 1'b0;
            if (ir.opcode == OP_LOADI) begin
              rf_we  <= 1'b1;
              wsel_q <= WSEL_DMEM;
              state  <= S_WB;
            end else begin
              pc    <= pc_inc;
              state <= S_FETCH;
            end
          end
        end
        S_WB: begin
          pc    <= pc_inc;
          state <= S_FETCH;
        end
        S_HALT: begin
          halted <= 1'b1;
        end
        default: state <= S_FETCH;
      endcase
    end
  end

endmodule
